// File: rtl/button_pkg.sv
// Shared state type, width helper and default timing for the button conditioning path.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rep_state_e;

  localparam int DEF_CHANNELS      = 4;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int ctr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One conditioned input: synchroniser, counter debounce, edge pulses and auto-repeat timer.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic cmd_pulse_o,
  output logic press_evt_o
);

  localparam int CW   = ctr_width(STABLE_CYCLES + 1);
  localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW   = ctr_width(TMAX);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LOAD  = TW'(REPEAT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [TW-1:0]          timer_q, timer_d;
  rep_state_e             state_q, state_d;
  logic                   level_q, press_q, release_q, cmd_q;
  logic                   sync_s, differ, flip, press_evt, release_evt, rep;

  assign sync_s      = sync_q[SYNC_STAGES-1];
  assign differ      = sync_s ^ level_q;
  assign flip        = differ && (cnt_q == CNT_LAST);
  assign press_evt   = flip & ~level_q;
  assign release_evt = flip & level_q;
  // Any agreeing sample restarts the stability count; an accepted flip does too.
  assign cnt_d       = (!differ || flip) ? '0 : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rep     = 1'b0;
    if (release_evt) begin
      state_d = IDLE;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_evt) begin
            state_d = HOLD;
            timer_d = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (repeat_en_i) begin
            rep     = 1'b1;
            state_d = REPEAT;
            timer_d = REP_LOAD;
          end
        end
        REPEAT: begin
          // Parking in HOLD at zero lets a re-enable fire on the very next cycle.
          if (!repeat_en_i) begin
            state_d = HOLD;
            timer_d = '0;
          end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            rep     = 1'b1;
            timer_d = REP_LOAD;
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cmd_q     <= 1'b0;
      timer_q   <= '0;
      state_q   <= IDLE;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_i};
      cnt_q     <= cnt_d;
      level_q   <= level_q ^ flip;
      press_q   <= press_evt;
      release_q <= release_evt;
      cmd_q     <= press_evt | rep;
      timer_q   <= timer_d;
      state_q   <= state_d;
    end
  end

  assign level_o         = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign cmd_pulse_o     = cmd_q;
  assign press_evt_o     = press_evt;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: independent per-channel pipelines plus a shared any-press flag.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CHANNELS      = DEF_CHANNELS,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] cmd_pulse,
  output logic                any_press
);

  logic [CHANNELS-1:0] press_evt;
  logic                any_press_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    button_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk_i          (clk),
      .rst_ni         (rst),
      .btn_i          (btn_in[g]),
      .repeat_en_i    (repeat_en[g]),
      .level_o        (level[g]),
      .press_pulse_o  (press_pulse[g]),
      .release_pulse_o(release_pulse[g]),
      .cmd_pulse_o    (cmd_pulse[g]),
      .press_evt_o    (press_evt[g])
    );
  end

  // Registered from the same events as press_pulse so both show in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= |press_evt;
    end
  end

  assign any_press = any_press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed and randomized bench for button_conditioner with a timestamp-based reference model.
module tb_button_conditioner;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int ST = 4;
  localparam int HC = 20;
  localparam int RC = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] btn_in, repeat_en;
  logic [CH-1:0] level, press_pulse, release_pulse, cmd_pulse;
  logic          any_press;

  always #5 clk = ~clk;

  button_conditioner #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .STABLE_CYCLES(ST),
    .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .repeat_en(repeat_en),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .cmd_pulse(cmd_pulse), .any_press(any_press)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference state: raw samples per edge, last accepted change, and next permitted repeat time.
  logic [CH-1:0] samp [8192];
  bit            lev [CH];
  int            lastflip [CH];
  bit            in_rep [CH];
  int            next_rep [CH];
  logic [CH-1:0] exp_level, exp_press, exp_release, exp_cmd;
  logic          exp_any;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [CH-1:0] p, r, rp;
    p = '0; r = '0; rp = '0;
    if (!rst) begin
      samp[cyc] = '0;
      for (int c = 0; c < CH; c++) begin
        lev[c] = 1'b0; lastflip[c] = cyc; in_rep[c] = 1'b0; next_rep[c] = 0;
      end
    end else begin
      samp[cyc] = btn_in;
      for (int c = 0; c < CH; c++) begin
        bit fl, held;
        // Accept when the last ST synchronised samples, all after the previous change, disagree.
        fl = 1'b1;
        for (int k = 0; k < ST; k++) begin
          if (cyc - k <= lastflip[c] || cyc - k - SS < 0) fl = 1'b0;
          else if (samp[cyc - k - SS][c] == lev[c]) fl = 1'b0;
        end
        held = lev[c];
        if (fl) begin
          lastflip[c] = cyc;
          if (lev[c]) r[c] = 1'b1; else p[c] = 1'b1;
          lev[c] = !lev[c];
        end
        if (p[c]) begin
          in_rep[c] = 1'b0; next_rep[c] = cyc + HC;
        end else if (r[c]) begin
          in_rep[c] = 1'b0;
        end else if (held) begin
          if (in_rep[c] && !repeat_en[c]) begin
            in_rep[c] = 1'b0; next_rep[c] = cyc + 1;
          end else if (repeat_en[c] && cyc >= next_rep[c]) begin
            rp[c] = 1'b1; in_rep[c] = 1'b1; next_rep[c] = cyc + RC;
          end
        end
      end
    end
    for (int c = 0; c < CH; c++) exp_level[c] = lev[c];
    exp_press = p; exp_release = r; exp_cmd = p | rp; exp_any = |p;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    chk("model_level",   32'(level),         32'(exp_level));
    chk("model_press",   32'(press_pulse),   32'(exp_press));
    chk("model_release", 32'(release_pulse), 32'(exp_release));
    chk("model_cmd",     32'(cmd_pulse),     32'(exp_cmd));
    chk("model_any",     32'(any_press),     32'(exp_any));
  endtask

  task automatic wait_press(input int c, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 12 && !seen; n++) begin
      step();
      if (press_pulse[c]) seen = 1'b1;
    end
    chk("wait_press", 32'(seen), 32'd1);
  endtask

  int  hold_left [CH];
  bit  tgt [CH];
  int  bnc [CH];
  bit  seen;
  int  rel_at;

  initial begin
    rst = 1'b0; btn_in = '0; repeat_en = '0;
    repeat (3) step();
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_cmd",   32'(cmd_pulse), 32'd0);
    rst = 1'b1;
    repeat (2) step();

    // Clean press then release on channel 0
    btn_in[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("s1_press", 32'(press_pulse[0]), 32'(i == 6));
      chk("s1_level", 32'(level[0]), 32'(i >= 6));
    end
    repeat (93) step();
    btn_in[0] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("s1_release", 32'(release_pulse[0]), 32'(i == 6));
      chk("s1_level_low", 32'(level[0]), 32'(i < 6));
    end

    // Bounce on channel 1, final rise at i=8
    for (int i = 0; i <= 20; i++) begin
      btn_in[1] = (i < 8) ? (((i / 2) % 2) == 0) : 1'b1;
      step();
      chk("s2_press", 32'(press_pulse[1]), 32'(i == 13));
      chk("s2_release", 32'(release_pulse[1]), 32'd0);
    end
    btn_in[1] = 1'b0;
    repeat (10) step();

    // Auto-repeat on channel 2
    repeat_en[2] = 1'b1; btn_in[2] = 1'b1;
    wait_press(2, seen);
    chk("s3_cmd_at_press", 32'(cmd_pulse[2]), 32'd1);
    rel_at = 0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 36) btn_in[2] = 1'b0;
      step();
      chk("s3_cmd", 32'(cmd_pulse[2]), 32'(i == 20 || i == 25 || i == 30 || i == 35 || i == 40));
      if (release_pulse[2]) rel_at = i;
    end
    chk("s3_release_at", 32'(rel_at), 32'd41);
    repeat_en[2] = 1'b0;

    // Repeat disabled and re-enabled mid-hold on channel 3
    repeat_en[3] = 1'b1; btn_in[3] = 1'b1;
    wait_press(3, seen);
    for (int i = 1; i <= 45; i++) begin
      if (i == 23) repeat_en[3] = 1'b0;
      if (i == 31) repeat_en[3] = 1'b1;
      step();
      chk("s4_cmd", 32'(cmd_pulse[3]), 32'(i == 20 || i == 31 || i == 36 || i == 41));
    end
    btn_in[3] = 1'b0; repeat_en = '0;
    repeat (10) step();

    // Simultaneous press, then reset while held
    btn_in = '1;
    wait_press(0, seen);
    chk("s5_press_all", 32'(press_pulse), 32'hF);
    chk("s5_any", 32'(any_press), 32'd1);
    step();
    chk("s5_any_drop", 32'(any_press), 32'd0);
    repeat (9) step();
    rst = 1'b0;
    #1;
    chk("s5_rst_level", 32'(level), 32'd0);
    chk("s5_rst_press", 32'(press_pulse), 32'd0);
    chk("s5_rst_cmd",   32'(cmd_pulse), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("s5_repress", 32'(press_pulse), (i == 6) ? 32'hF : 32'h0);
    end
    btn_in = '0;
    repeat (10) step();

    // Randomized phase with bounce bursts, enable toggles and one mid-run reset
    for (int c = 0; c < CH; c++) begin
      tgt[c] = 1'b0; bnc[c] = 0; hold_left[c] = int'($urandom_range(3, 40));
    end
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) rst = 1'b0;
      if (n == 703) rst = 1'b1;
      for (int c = 0; c < CH; c++) begin
        if (bnc[c] > 0) begin
          btn_in[c] = 1'($urandom_range(0, 1));
          bnc[c]--;
        end else if (hold_left[c] == 0) begin
          tgt[c] = !tgt[c];
          hold_left[c] = int'($urandom_range(5, 70));
          bnc[c] = int'($urandom_range(0, 5));
          btn_in[c] = tgt[c];
        end else begin
          hold_left[c]--;
          btn_in[c] = tgt[c];
        end
        if ($urandom_range(0, 29) == 0) repeat_en[c] = !repeat_en[c];
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Multi-channel successor to the single-bit debounce/one-pulse pair used for the stop button.
- Conditions CHANNELS raw pushbutton or switch inputs through four stages: synchronise, counter-based debounce, press/release edge pulses, optional per-channel auto-repeat.
- Sits between board pins and game control (stop/pause, direction buttons as keyboard fallback).
- Its outputs are single-cycle command pulses, so Game_Ctrl_Unit and Snake consume them directly.

Parameters:
- CHANNELS, 4, number of independent input channels (1..16).
- SYNC_STAGES, 2, synchroniser flops per channel (min 2).
- STABLE_CYCLES, 4, consecutive agreeing samples required to accept a new level (min 1).
- HOLD_CYCLES, 50000000, cycles of continuous press before the first repeat pulse (min 1).
- REPEAT_CYCLES, 10000000, cycles between subsequent repeat pulses (min 1).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_in  input  CHANNELS  raw asynchronous button levels, 1 = pressed.
- repeat_en  input  CHANNELS  per-channel auto-repeat enable, sampled every cycle.
- level  output  CHANNELS  debounced button level.
- press_pulse  output  CHANNELS  one-cycle pulse on accepted 0->1.
- release_pulse  output  CHANNELS  one-cycle pulse on accepted 1->0.
- cmd_pulse  output  CHANNELS  press_pulse OR repeat pulse; the game-facing command.
- any_press  output  1  OR-reduction of press_pulse, registered.

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchroniser flops, level, all pulses, any_press, debounce counters and repeat timers go to 0.
  - Every repeat FSM goes to IDLE.
- Synchroniser: btn_in passes through SYNC_STAGES flops; the last stage is sync_q.
- Debounce, per channel:
  - Counter width is clog2(STABLE_CYCLES+1).
  - If sync_q == level, the counter clears.
  - Otherwise the counter increments.
  - When the counter == STABLE_CYCLES-1 and sync_q still differs, level flips on that edge and the counter clears.
  - Any intervening agreeing sample clears the counter, so glitches shorter than STABLE_CYCLES never propagate.
- Latency: a clean input edge appears on level exactly SYNC_STAGES+STABLE_CYCLES cycles later (6 with defaults).
- Edge pulses:
  - press_pulse and release_pulse are registered and high for exactly the cycle in which level first shows its new value.
  - They are never high together on one channel.
- Repeat FSM, per channel, with states IDLE, HOLD, REPEAT:
  - IDLE: on accepted press, go to HOLD and load timer with HOLD_CYCLES-1.
  - HOLD: the timer decrements each cycle. At 0 with repeat_en=1: assert rep for 1 cycle, go to REPEAT, load REPEAT_CYCLES-1. At 0 with repeat_en=0: remain in HOLD with timer held at 0 and no pulse.
  - REPEAT: the timer decrements. At 0: rep pulse, reload REPEAT_CYCLES-1.
  - If repeat_en falls while in REPEAT: go to HOLD with timer 0, no pulse. Re-enabling then fires on the next cycle.
  - From any state, an accepted release goes to IDLE, clears the timer and produces no rep.
- Timer width is clog2(max(HOLD_CYCLES, REPEAT_CYCLES)). The timer never wraps; it saturates at 0.
- First rep occurs HOLD_CYCLES cycles after press_pulse. Later reps occur every REPEAT_CYCLES cycles.
- cmd_pulse = press_pulse | rep, registered with the same timing as press_pulse.
  - The press cycle never coincides with rep, because HOLD_CYCLES ≥ 1.
- any_press: registered OR of the press conditions, aligned with press_pulse (same cycle).
- Channels are fully independent. Simultaneous presses on several channels yield simultaneous pulses.
- Reset mid-press: all outputs drop immediately. After release of reset, a still-held button is re-accepted after the normal latency and produces a fresh press_pulse.

Decomposition:
- Package button_pkg holds:
  - the repeat-state typedef (IDLE/HOLD/REPEAT);
  - a clog2-based width helper function;
  - named default constants for the timing parameters.
- Sub-module button_channel implements one channel (synchroniser, debounce, edge detect, repeat FSM).
- The top module instantiates button_channel CHANNELS times via generate and builds any_press.

Test Plan:
All scenarios use CHANNELS=4, SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5.
- Clean press/release: btn_in[0] rises at cycle 0 and is held for 100 cycles.
  - Required: level[0] and press_pulse[0] at cycle 6. release_pulse[0] 6 cycles after the falling edge. Both pulses exactly 1 cycle wide.
- Bounce rejection: btn_in[1] toggles 1,0,1,0,1 every 2 cycles, then stays 1.
  - Required: no output activity during the bounce. A single press_pulse[1] 6 cycles after the final rise.
- Auto-repeat: repeat_en[2]=1, btn_in[2] held for 40 cycles after acceptance.
  - Required: cmd_pulse[2] at press, then at +20, +25, +30, +35, +40. No rep after release.
- Repeat disabled mid-hold: repeat_en[3] drops at +22 and rises at +30.
  - Required: no pulses from +22 to +30. cmd_pulse at +31, then every 5 cycles.
- Simultaneous/reset: channels 0–3 pressed together, then rst pulsed low at +10 while held.
  - Required: four concurrent press_pulses and any_press=1 for 1 cycle. All outputs 0 during reset. Fresh press_pulses 6 cycles after reset release.
